// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller beside the ID/EX register.
// Latency: selects are registered, valid one cycle after ID (aligned with EX); stall is combinational.
// Backpressure: raises stall on load-use; hold freezes all state; ex_branch_taken squashes ID.
//
// Ports:
//   clk, rst_n (sync, active-low), hold        : clock, reset, global freeze
//   id_valid/id_rs1/id_rs2/id_use_rs1/id_use_rs2: instruction in ID and the sources it reads
//   id_rd/id_regwrite/id_memread               : destination info carried down EX/MEM/WB
//   ex_branch_taken                            : taken branch in EX, squash ID
//   stall                                      : hold PC and IF/ID, bubble into EX
//   fwd_a_sel/fwd_b_sel                        : 0 regfile, 1 MEM ALU result, 2 WB result
//   stall_count                                : saturating count of load-use stall cycles
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } entry_t;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  entry_t ex_q, mem_q, wb_q;
  entry_t id_e;

  logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic       advance;
  logic [1:0] sel_a_nxt, sel_b_nxt;

  // An entry can supply a source only if it really writes a non-zero rd.
  function automatic logic hit(input entry_t e, input logic [REG_AW-1:0] src, input logic use_src);
    return e.valid & e.regwrite & (e.rd != '0) & (e.rd == src) & use_src;
  endfunction

  assign id_e = {1'b1, id_rd, id_regwrite, id_memread};

  assign ex_hit_a  = id_valid & hit(ex_q,  id_rs1, id_use_rs1);
  assign ex_hit_b  = id_valid & hit(ex_q,  id_rs2, id_use_rs2);
  assign mem_hit_a = id_valid & hit(mem_q, id_rs1, id_use_rs1);
  assign mem_hit_b = id_valid & hit(mem_q, id_rs2, id_use_rs2);

  // Load data is not available until the load reaches WB, so a consumer directly
  // behind a load waits one cycle. A taken branch kills the consumer instead.
  assign stall   = (ex_hit_a | ex_hit_b) & ex_q.memread & ~ex_branch_taken;
  assign advance = id_valid & ~stall & ~ex_branch_taken;

  // The younger producer (EX) wins over MEM. A load sitting in MEM is picked up
  // one cycle later from WB load data, hence the same WB select as an ALU result.
  always_comb begin
    sel_a_nxt = SEL_RF;
    if (ex_hit_a & ~ex_q.memread) sel_a_nxt = SEL_MEM;
    else if (mem_hit_a)           sel_a_nxt = SEL_WB;
  end

  always_comb begin
    sel_b_nxt = SEL_RF;
    if (ex_hit_b & ~ex_q.memread) sel_b_nxt = SEL_MEM;
    else if (mem_hit_b)           sel_b_nxt = SEL_WB;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_sel   <= SEL_RF;
      fwd_b_sel   <= SEL_RF;
      stall_count <= '0;
    end else if (!hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (advance) begin
        ex_q      <= id_e;
        fwd_a_sel <= sel_a_nxt;
        fwd_b_sel <= sel_b_nxt;
      end else begin
        ex_q      <= '0;
        fwd_a_sel <= SEL_RF;
        fwd_b_sel <= SEL_RF;
      end
      if (stall && (stall_count != '1))
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // The WB entry and MEM's load flag are tracked for pipeline visibility only: the
  // regfile is write-first, so WB never needs to be a forwarding source.
  logic unused_wb;
  assign unused_wb = ^{wb_q, mem_q.memread};

endmodule
